fos_inverse_seq: RTL and testbench
==================================

Name: fos_inverse_seq

Overview:
- Inverse (analysis) first-order section for the fixed-point forward section y[n] = x[n-1] - x[n-2] - a1*y[n-1].
- Consumes the filtered stream y and reconstructs the excitation: x = x_prev + y_in + ((a1*y_prev) >>> FRAC).
- Uses a sequential radix-4 Booth multiplier, one recoded digit per cycle, with valid/ready handshakes on both sides.
- Sits downstream of the forward section in the reference/verification chain. Cascading the two gives bit-exact recovery of x, delayed by one sample.

Parameters:
- WIDTH, 32, data and coefficient width; must be even.
- FRAC, 30, fractional bits of a1 (Q2.30 by default); 0 <= FRAC < WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  y_in/a1 valid.
- in_ready  output  1  block can accept a sample.
- y_in  input  WIDTH  signed filtered sample.
- a1  input  WIDTH  signed feedback coefficient; sampled at input acceptance.
- flush  input  1  zero the history registers; honoured in IDLE only.
- out_valid  output  1  x_out valid.
- out_ready  input  1  downstream accepts x_out.
- x_out  output  WIDTH  signed reconstructed sample.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high; clock clk): state=IDLE; x_prev=0, y_prev=0, x_out=0; out_valid=0, busy=0, in_ready=1. Reset wins over every other event, including mid-multiply and mid-OUT. An in-flight sample is discarded and no out_valid is produced.
- States: IDLE, MUL, ACC, OUT.
- IDLE:
  - in_ready=1.
  - Acceptance occurs on the edge where in_valid & in_ready. On that edge: latch y_in into y_cur, latch a1, load the multiplicand y_prev, clear the product and the counter, go to MUL.
  - flush=1 without in_valid: clear x_prev and y_prev, stay in IDLE.
  - flush and in_valid together: flush takes effect first, the sample is accepted, and the product uses y_prev=0.
- MUL:
  - Radix-4 Booth on a1 (multiplier) x y_prev (multiplicand).
  - WIDTH/2 cycles, one digit per cycle from {-2,-1,0,+1,+2}.
  - Full 2*WIDTH signed product, exact.
  - After the last digit, go to ACC.
- ACC (1 cycle):
  - p = product bits [FRAC+WIDTH-1 : FRAC]. This is an arithmetic shift, i.e. floor rounding, then truncation to WIDTH.
  - x_out <= x_prev + y_cur + p, modulo 2^WIDTH (wrap, no saturation).
  - x_prev <= that result; y_prev <= y_cur.
  - Go to OUT.
- OUT:
  - out_valid=1; x_out is held stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, go to IDLE.
  - in_ready=0 throughout OUT.
- Latency and throughput (WIDTH=32): out_valid rises after the 17th rising edge following the accepting edge. Minimum sample period is 19 cycles when out_ready=1.
- in_ready is 0 in MUL, ACC and OUT. in_valid is ignored there, and y_in/a1 may change freely.
- Register widths: x_prev and y_prev are WIDTH bits; the product register is 2*WIDTH+2 bits (Booth guard bits).

Test Plan:
- Basic: reset, a1=0x4000_0000 (1.0), y_in=5 → x_out=5. Then y_in=3 → x_out=5+3+5=13. Each out_valid rises exactly 17 edges after acceptance.
- Rounding and sign: preload y_prev=-3 (x_prev=0), a1=0x2000_0000 (0.5), y_in=0 → p=floor(-1.5)=-2, x_out=0xFFFF_FFFE. Also a1=0xC000_0000 (-1.0), y_prev=7 → p=-7.
- Wrap: x_prev=0x7FFF_FFFF, y_prev=0, y_in=1 → x_out=0x8000_0000. Booth extremes: a1=0x8000_0000, y_prev=0x8000_0000, FRAC=30 → p=0x0000_0000 (low bits of 2^32 truncated). The product must match a 64-bit reference.
- Backpressure and handshake: hold out_ready=0 for 10 cycles in OUT → x_out stable, in_ready=0, and in_valid pulses are not consumed. Release → one transfer, IDLE next cycle.
- Reset mid-operation: assert reset on MUL cycle 6 → next cycle IDLE, in_ready=1, out_valid=0, history zero. The next sample y_in=9 → x_out=9. Flush in IDLE after non-zero history → the next output equals y_in.
- Cascade: random x (1000 samples) and random a1 through a bit-exact model of the forward section → this block → x_out[k] == x[k-1] for all k, including with random out_ready stalls.

Source files
------------

// File: rtl/fos_inverse_seq.sv
// fos_inverse_seq
//   Inverse (analysis) first-order section. Takes the output y of the forward
//   section y[n] = x[n-1] - x[n-2] - a1*y[n-1] and rebuilds the excitation:
//     x = x_prev + y_in + ((a1 * y_prev) >>> FRAC)
//   The product is formed by a sequential radix-4 Booth multiplier that
//   retires one recoded digit per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid_i / in_ready  -> in_valid / in_ready : input handshake
//   y_in       signed filtered sample
//   a1         signed feedback coefficient, Q(WIDTH-FRAC).FRAC
//   flush      clear x_prev / y_prev (acted on in IDLE only)
//   out_valid / out_ready  : output handshake
//   x_out      signed reconstructed sample, held until transferred
//   busy       high whenever the block is not IDLE
module fos_inverse_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] a1,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic                    busy
);

  localparam int HW   = WIDTH + 2;        // accumulator half incl. Booth guard bits
  localparam int PW   = 2 * WIDTH + 2;    // full product register
  localparam int NDIG = WIDTH / 2;        // radix-4 digits per multiply
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_OUT
  } state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] x_prev_q;
  logic signed [WIDTH-1:0] y_prev_q;
  logic signed [WIDTH-1:0] y_cur_q;
  logic signed [WIDTH-1:0] x_out_q;
  logic signed [HW-1:0]    mcand_q;
  logic [PW-1:0]           prod_q;
  logic [PW-1:0]           prod_d;
  logic                    booth_lsb_q;
  logic [CW-1:0]           cnt_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  logic signed [HW-1:0]    hi_sum;
  logic signed [WIDTH-1:0] p_trunc;
  logic signed [WIDTH-1:0] x_new;

  // Add one recoded Booth digit times the multiplicand to the upper half.
  // Digit from {b(2i+1), b(2i), b(2i-1)}: 0, +1, +1, +2, -2, -1, -1, 0.
  function automatic logic signed [HW-1:0] booth_step(
    input logic signed [HW-1:0] acc,
    input logic [2:0]           bits,
    input logic signed [HW-1:0] m
  );
    logic signed [HW-1:0] r;
    r = acc;
    case (bits)
      3'b001, 3'b010: r = acc + m;
      3'b011:         r = acc + (m <<< 1);
      3'b100:         r = acc - (m <<< 1);
      3'b101, 3'b110: r = acc - m;
      default:        r = acc;
    endcase
    return r;
  endfunction

  always_comb begin
    hi_sum  = booth_step($signed(prod_q[PW-1:WIDTH]), {prod_q[1:0], booth_lsb_q}, mcand_q);
    // Arithmetic right shift of the whole register by one digit (2 bits);
    // the consumed multiplier bits fall off the bottom.
    prod_d  = {{2{hi_sum[HW-1]}}, hi_sum, prod_q[WIDTH-1:2]};
    // Taking bits [FRAC+WIDTH-1:FRAC] is a floor shift followed by wrap.
    p_trunc = $signed(prod_q[FRAC+WIDTH-1:FRAC]);
    x_new   = x_prev_q + y_cur_q + p_trunc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            y_cur_q     <= y_in;
            // Multiplier lives in the low half and is consumed as it shifts out.
            prod_q      <= {{(WIDTH + 2){1'b0}}, a1};
            booth_lsb_q <= 1'b0;
            cnt_q       <= '0;
            // A simultaneous flush clears history first, so the product sees 0.
            if (flush) begin
              mcand_q  <= '0;
              x_prev_q <= '0;
              y_prev_q <= '0;
            end else begin
              mcand_q  <= {{2{y_prev_q[WIDTH-1]}}, y_prev_q};
            end
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_MUL;
          end else if (flush) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
          end
        end
        S_MUL: begin
          prod_q      <= prod_d;
          booth_lsb_q <= prod_q[1];
          cnt_q       <= cnt_q + CW'(1);
          if (cnt_q == CW'(NDIG - 1)) begin
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          x_out_q     <= x_new;
          x_prev_q    <= x_new;
          y_prev_q    <= y_cur_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x_out     = x_out_q;

endmodule

// File: tb/tb_fos_inverse_seq.sv
// Testbench for fos_inverse_seq (WIDTH=32, FRAC=30).
// Expected outputs are queued when a sample is driven and popped when the
// DUT presents x_out.
module tb_fos_inverse_seq;

  localparam int W = 32;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                in_valid  = 1'b0;
  logic                flush     = 1'b0;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] y_in      = '0;
  logic signed [W-1:0] a1        = '0;
  logic                in_ready;
  logic                out_valid;
  logic                busy;
  logic signed [W-1:0] x_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fos_inverse_seq #(.WIDTH(32), .FRAC(30)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .a1        (a1),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Forward-section feedback term: floor((a*y) / 2^30) wrapped to 32 bits.
  function automatic logic [31:0] fwd_p(input logic [31:0] a, input logic [31:0] y);
    longint prod;
    prod = longint'($signed(a)) * longint'($signed(y));
    prod = prod >>> 30;
    return prod[31:0];
  endfunction

  // Present one sample once in_ready is seen; returns just after the accepting edge.
  task automatic send(input logic [31:0] y, input logic [31:0] a, input logic fl,
                      input logic [31:0] expv);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_send", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    y_in     = y;
    a1       = a;
    flush    = fl;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    y_in     = $urandom;
    a1       = $urandom;
  endtask

  // Wait for out_valid, optionally stall, compare, and confirm return to IDLE.
  task automatic get(input string tag, input bit stall);
    int n;
    int s;
    logic [31:0] expv;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 32'd17);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    if (stall) begin
      s = 0;
      while ($urandom_range(0, 2) == 0 && s < 8) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        s++;
      end
    end
    out_ready = 1'b1;
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk(tag, x_out, expv);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {29'b0, out_valid, busy, in_ready}, 32'b001);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {30'b0, busy, in_ready}, 32'b01);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold_val;
    logic [31:0] dummy;
    int seen;
    logic [31:0] xm1, xm2, fy_prev, xk, ak, yk;

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_x_out", x_out, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic: a1 = 1.0
    send(32'd5, 32'h4000_0000, 1'b0, 32'd5);
    get("basic0", 1'b0);
    send(32'd3, 32'h4000_0000, 1'b0, 32'd13);
    get("basic1", 1'b0);

    // Rounding: x_prev=0, y_prev=-3, a1=0.5 -> p=floor(-1.5)=-2
    do_flush();
    send(32'd3, 32'h0, 1'b0, 32'd3);
    get("pre_r0", 1'b0);
    send(32'hFFFF_FFFD, 32'h0, 1'b0, 32'd0);
    get("pre_r1", 1'b0);
    send(32'd0, 32'h2000_0000, 1'b0, 32'hFFFF_FFFE);
    get("round_neg", 1'b0);

    // Sign: a1=-1.0, y_prev=7 -> p=-7 ; x_prev=5, y_in=10 -> 8
    send(32'd7, 32'h0, 1'b0, 32'd5);
    get("pre_s0", 1'b0);
    send(32'd10, 32'hC000_0000, 1'b0, 32'd8);
    get("sign_m1", 1'b0);

    // Wrap: 0x7FFFFFFF + 1 with zero product
    do_flush();
    send(32'h7FFF_FFFF, 32'h0, 1'b0, 32'h7FFF_FFFF);
    get("pre_w0", 1'b0);
    send(32'd1, 32'h0, 1'b0, 32'h8000_0000);
    get("wrap", 1'b0);

    // Booth extremes
    do_flush();
    send(32'h8000_0000, 32'h0, 1'b0, 32'h8000_0000);
    get("pre_b0", 1'b0);
    // (2^31-1)*(-2^31) >>> 30 = -2^32+2 -> 2 ; x = 0x80000000+0x80000000+2
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd2);
    get("booth_maxneg", 1'b0);
    // (-2^31)*(-2^31) = 2^62 -> bits [61:30] are zero
    send(32'd5, 32'h8000_0000, 1'b0, 32'd7);
    get("booth_negneg", 1'b0);

    // Backpressure: x_prev=7, y_prev=5, a1=1.0, y_in=1 -> 13
    out_ready = 1'b0;
    send(32'd1, 32'h4000_0000, 1'b0, 32'd13);
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("bp_lat", seen, 32'd17);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      y_in     = $urandom;
      @(posedge clk); #1;
      chk("bp_x_stable", x_out, 32'd13);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hold_val = exp_q.pop_front();
    chk("bp_release", x_out, hold_val);
    @(posedge clk); #1;
    chk("bp_idle", {29'b0, out_valid, busy, in_ready}, 32'b001);
    // History untouched by the ignored pulses: 13 + 2 + 1
    send(32'd2, 32'h4000_0000, 1'b0, 32'd16);
    get("bp_after", 1'b0);

    // Reset during MUL cycle 6
    send(32'd100, 32'h4000_0000, 1'b0, 32'd0);
    dummy = exp_q.pop_back();
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_x_out", x_out, 32'd0);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_out", seen, 32'd0);
    send(32'd9, 32'h4000_0000, 1'b0, 32'd9);
    get("mrst_after", 1'b0);

    // Flush alone, then flush together with a sample
    do_flush();
    send(32'd4, 32'h4000_0000, 1'b0, 32'd4);
    get("flush_alone", 1'b0);
    send(32'd6, 32'h4000_0000, 1'b1, 32'd6);
    get("flush_with_in", 1'b0);

    // Cascade: forward model -> DUT -> x delayed by one sample
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    xm1 = '0;
    xm2 = '0;
    fy_prev = '0;
    for (int k = 0; k < 1000; k++) begin
      xk = $urandom;
      ak = $urandom;
      yk = xm1 - xm2 - fwd_p(ak, fy_prev);
      send(yk, ak, 1'b0, xm1);
      get("cascade", 1'b1);
      xm2 = xm1;
      xm1 = xk;
      fy_prev = yk;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
